// File: rtl/vga_pkg.sv
// Shared screen geometry, colour constants, FSM state encoding and box record
// for the VGA plotting path.
package vga_pkg;

    localparam int SCR_W_DEFAULT = 160;
    localparam int SCR_H_DEFAULT = 120;

    localparam logic [2:0] COLOUR_WHITE = 3'b111;
    localparam logic [2:0] COLOUR_BLUE  = 3'b001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ERASE = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } box_t;

endpackage

// File: rtl/box_scan_counter.sv
// Row-major cx/cy scan over a W x H box; cx is the inner loop.
// The next-count outputs let the owner register pixel data one cycle early.
module box_scan_counter #(
    parameter int W = 4,
    parameter int H = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] cx,
    output logic [3:0] cy,
    output logic [3:0] cx_next,
    output logic [3:0] cy_next,
    output logic       last
);

    localparam logic [3:0] CX_MAX = 4'(W - 1);
    localparam logic [3:0] CY_MAX = 4'(H - 1);

    always_comb begin
        cx_next = cx;
        cy_next = cy;
        if (clear) begin
            cx_next = 4'd0;
            cy_next = 4'd0;
        end else if (enable) begin
            if (cx == CX_MAX) begin
                cx_next = 4'd0;
                cy_next = (cy == CY_MAX) ? 4'd0 : cy + 4'd1;
            end else begin
                cx_next = cx + 4'd1;
            end
        end
    end

    assign last = (cx == CX_MAX) && (cy == CY_MAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx <= 4'd0;
            cy <= 4'd0;
        end else begin
            cx <= cx_next;
            cy <= cy_next;
        end
    end

endmodule

// File: rtl/box_plotter.sv
// Rasterises one box request per handshake into the VGA adapter plot port,
// optionally erasing the previously drawn box first.
//
// state | meaning
// IDLE  | ready for a request, forget clears the remembered box at once
// ERASE | repaint previous box in background colour
// DRAW  | paint the new box in its latched colour
// DONE  | one-cycle done pulse, then back to IDLE
module box_plotter
    import vga_pkg::*;
#(
    parameter int         BOX_W     = 4,
    parameter int         BOX_H     = 3,
    parameter logic [2:0] BG_COLOUR = COLOUR_WHITE,
    parameter int         ERASE_EN  = 1,
    parameter int         SCR_W     = SCR_W_DEFAULT,
    parameter int         SCR_H     = SCR_H_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    input  logic       forget,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    box_t       new_box;
    box_t       prev_box;
    box_t       req_box;
    box_t       base;
    logic       prev_valid;
    logic       forget_pend;
    logic       accept;

    logic [3:0] cx, cy, cx_nxt, cy_nxt;
    logic       scan_last;
    logic       scan_clear;
    logic       scan_en;

    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic [2:0] pix_colour;
    logic       drawing_nxt;
    logic       in_view;

    assign req_box = '{x: req_x, y: req_y, colour: req_colour};
    assign accept  = (state == ST_IDLE) && req_valid && req_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)
                          state_nxt = ((ERASE_EN != 0) && prev_valid && !forget) ? ST_ERASE : ST_DRAW;
            ST_ERASE: if (scan_last) state_nxt = ST_DRAW;
            ST_DRAW:  if (scan_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign scan_clear = accept || ((state == ST_ERASE) && scan_last);
    assign scan_en    = (state == ST_ERASE) || (state == ST_DRAW);

    box_scan_counter #(.W(BOX_W), .H(BOX_H)) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (scan_clear),
        .enable  (scan_en),
        .cx      (cx),
        .cy      (cy),
        .cx_next (cx_nxt),
        .cy_next (cy_nxt),
        .last    (scan_last)
    );

    // Outputs are registered from the next state/count so the first pixel
    // lands in the cycle right after acceptance.
    always_comb begin
        if (state_nxt == ST_ERASE)
            base = prev_box;
        else if (accept)
            base = req_box;
        else
            base = new_box;
        pix_colour  = (state_nxt == ST_ERASE) ? BG_COLOUR : base.colour;
        sum_x       = {1'b0, base.x} + {5'b0, cx_nxt};
        sum_y       = {1'b0, base.y} + {4'b0, cy_nxt};
        in_view     = (sum_x < 9'(SCR_W)) && (sum_y < 8'(SCR_H));
        drawing_nxt = (state_nxt == ST_ERASE) || (state_nxt == ST_DRAW);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            vga_plot  <= drawing_nxt && in_view;
            busy      <= drawing_nxt;
            done      <= (state_nxt == ST_DONE);
            req_ready <= (state_nxt == ST_IDLE);
            if (drawing_nxt) begin
                vga_x      <= sum_x[7:0];
                vga_y      <= sum_y[6:0];
                vga_colour <= pix_colour;
            end
        end
    end

    // forget seen mid-request is held until the box is finished so the
    // current erase/draw is never cut short.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            new_box     <= '0;
            prev_box    <= '0;
            prev_valid  <= 1'b0;
            forget_pend <= 1'b0;
        end else begin
            if (accept)
                new_box <= req_box;
            if ((state == ST_DRAW) && scan_last) begin
                prev_box    <= new_box;
                prev_valid  <= !(forget_pend || forget);
                forget_pend <= 1'b0;
            end else if ((state == ST_IDLE) || (state == ST_DONE)) begin
                if (forget)
                    prev_valid <= 1'b0;
            end else if (forget) begin
                forget_pend <= 1'b1;
            end
        end
    end

endmodule
